mat_view_engine: RTL

- Parametrised successor to the lab5 single-size matrix unit: stores one square matrix of up to 2^LOG_MAX_N x 2^LOG_MAX_N unsigned words.
- Executes load, element-wise add/sub, transpose, mirror, rotate-90, trace and read commands.
- Transforms cost O(1): a 3-bit orientation register remaps addresses, so no data moves.
- Sits behind the lab testbench-style in_valid/action command port and streams results on out_valid/out_data.

---
 rtl/mat_view_if.sv | 14 +
 rtl/mat_view_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_view_if.sv
// Command/result port of mat_view_engine: beat-qualified command input and result stream.
interface mat_view_if #(
   parameter int DATA_W = 31
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [1:0]        size;
   logic [2:0]        action;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;

   modport master (output in_valid, in_data, size, action, input out_valid, out_data);
   modport slave  (input in_valid, in_data, size, action, output out_valid, out_data);
endinterface

// File: rtl/mat_view_engine.sv
// Square-matrix engine: data commands, O(1) transforms via an orientation register
// that remaps logical (r,c) to physical storage, trace, and row-major result streaming.
module mat_view_engine #(
   parameter int DATA_W    = 31,
   parameter int LOG_MAX_N = 4,
   parameter int SAT       = 0
) (
   input  logic      clk,
   input  logic      rst_n,
   mat_view_if.slave bus
);
   localparam int MAX_N = 1 << LOG_MAX_N;
   localparam int DEPTH = MAX_N * MAX_N;
   localparam int LW    = LOG_MAX_N;
   localparam int AW    = 2 * LOG_MAX_N;
   localparam int KW    = AW + 1;
   localparam logic [DATA_W-1:0] W_MAX     = '1;
   localparam logic [2:0]        LOG_LIMIT = 3'(LOG_MAX_N);

   typedef enum logic [2:0] {S_IDLE, S_IN, S_EXEC, S_WAIT, S_OUT} state_e;
   typedef enum logic [2:0] {
      A_LOAD, A_ADD, A_SUB, A_TRANSPOSE, A_MIRROR, A_ROT90, A_TRACE, A_READ
   } action_e;
   typedef struct packed {
      logic swap;
      logic flip_r;
      logic flip_c;
   } orient_t;

   function automatic logic [AW-1:0] phys_rc(input logic [LW-1:0] r, input logic [LW-1:0] c,
                                             input logic [2:0] log_n, input orient_t o);
      logic [LW-1:0] last, a, b;
      last = LW'((1 << log_n) - 1);
      a = o.swap ? c : r;
      b = o.swap ? r : c;
      if (o.flip_r) a = last - a;
      if (o.flip_c) b = last - b;
      return {a, b};
   endfunction

   function automatic logic [AW-1:0] phys_k(input logic [KW-1:0] k, input logic [2:0] log_n,
                                            input orient_t o);
      logic [LW-1:0] last;
      last = LW'((1 << log_n) - 1);
      return phys_rc(LW'(k >> log_n), LW'(k) & last, log_n, o);
   endfunction

   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
      logic [DATA_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      return (SAT != 0 && s[DATA_W]) ? W_MAX : s[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
      return (SAT != 0 && y > x) ? '0 : x - y;
   endfunction

   state_e            state_q, state_d;
   action_e           act_q, act_d, cmd;
   orient_t           orient_q, orient_d;
   logic [2:0]        log_n_q, log_n_d, size_n, size_p1;
   logic [KW-1:0]     idx_q, idx_d, n_cnt, nn_cnt, out_total, wr_k;
   logic [DATA_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_en;
   logic [AW-1:0]     wr_addr, rd_addr, diag_addr;
   logic [DATA_W-1:0] wr_data, wr_old;

   assign cmd       = action_e'(bus.action);
   assign size_p1   = {1'b0, bus.size} + 3'd1;
   assign size_n    = (size_p1 > LOG_LIMIT) ? LOG_LIMIT : size_p1;
   assign n_cnt     = KW'(1) << log_n_q;
   assign nn_cnt    = KW'(1) << {log_n_q, 1'b0};
   assign out_total = (act_q == A_TRACE) ? KW'(1) : nn_cnt;
   assign rd_addr   = phys_k((state_q == S_WAIT) ? KW'(0) : idx_q, log_n_q, orient_q);
   assign diag_addr = phys_rc(LW'(idx_q), LW'(idx_q), log_n_q, orient_q);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      act_d       = act_q;
      orient_d    = orient_q;
      log_n_d     = log_n_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      wr_en       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               act_d = cmd;
               idx_d = KW'(1);
               acc_d = '0;
               // Transforms only rewrite the view; ROT90 is transpose followed by mirror.
               case (cmd)
                  A_LOAD: begin
                     log_n_d  = size_n;
                     orient_d = '0;
                  end
                  A_TRANSPOSE: orient_d.swap = ~orient_q.swap;
                  A_MIRROR: begin
                     if (orient_q.swap) orient_d.flip_r = ~orient_q.flip_r;
                     else               orient_d.flip_c = ~orient_q.flip_c;
                  end
                  A_ROT90: begin
                     orient_d.swap = ~orient_q.swap;
                     if (orient_q.swap) orient_d.flip_c = ~orient_q.flip_c;
                     else               orient_d.flip_r = ~orient_q.flip_r;
                  end
                  default: ;
               endcase
               if (cmd inside {A_LOAD, A_ADD, A_SUB}) begin
                  wr_en   = 1'b1;
                  state_d = S_IN;
               end else if (cmd == A_TRACE) begin
                  idx_d   = '0;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_IN: begin
            if (bus.in_valid) begin
               wr_en = 1'b1;
               idx_d = idx_q + KW'(1);
               if (idx_q == nn_cnt - KW'(1)) state_d = S_WAIT;
            end
         end
         S_EXEC: begin
            acc_d = sat_add(acc_q, mem_q[diag_addr]);
            idx_d = idx_q + KW'(1);
            if (idx_q == n_cnt - KW'(1)) state_d = S_WAIT;
         end
         S_WAIT: begin
            out_valid_d = 1'b1;
            out_data_d  = (act_q == A_TRACE) ? acc_q : mem_q[rd_addr];
            idx_d       = KW'(1);
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (idx_q == out_total) begin
               state_d = S_IDLE;
            end else begin
               out_valid_d = 1'b1;
               out_data_d  = mem_q[rd_addr];
               idx_d       = idx_q + KW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Writes use the view being established this cycle, so a LOAD's first beat lands correctly.
   always_comb begin
      wr_k    = (state_q == S_IDLE) ? KW'(0) : idx_q;
      wr_addr = phys_k(wr_k, log_n_d, orient_d);
      wr_old  = mem_q[wr_addr];
      case (act_d)
         A_ADD:   wr_data = sat_add(wr_old, bus.in_data);
         A_SUB:   wr_data = sat_sub(wr_old, bus.in_data);
         default: wr_data = bus.in_data;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         act_q       <= A_READ;
         orient_q    <= '0;
         log_n_q     <= 3'd1;
         idx_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         orient_q    <= orient_d;
         log_n_q     <= log_n_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: storage is a flop array with async clear because reset must zero every word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule
